// File: rtl/alu_pkg.sv
// Shared definitions for the serial add/subtract stage: sequencer states and
// the default operand width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used as the bit-slice of the serial adder.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract stage. Operands are accepted over a valid/ready
// handshake, fed LSB-first through a single FullAdder over WIDTH cycles, and
// the result with carry, overflow and zero flags is held on a second
// valid/ready handshake until the consumer takes it.
module serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    // Output holding registers: res_sh and carry are reused by the next job,
    // so the presented result lives in its own flops and stays put until the
    // following job completes.
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ovf_r;
    logic             zero_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    FullAdder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign res_next = {fa_sum, res_sh[WIDTH-1:1]};
    assign last_bit = (state == RUN) && (cnt == LAST_BIT);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, run WIDTH bit cycles, wait for the consumer.
    // NOTE: default assignment first so no path through the block infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: load operands on accept, shift one bit per RUN cycle, capture
    // the finished result and flags on the last bit.
    // NOTE: every datapath register is reset so an aborted job leaves nothing
    // behind and the outputs read as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_r    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
                        b_sh  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    carry  <= fa_cout;
                    if (last_bit) begin
                        result_q <= res_next;
                        cout_q   <= fa_cout;
                        // Carry into the MSB differs from carry out: signed overflow.
                        ovf_r    <= carry ^ fa_cout;
                        zero_q   <= (res_next == '0);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_r;
    assign zero   = zero_q;

endmodule
